// File: rtl/key_conditioner_if.sv
`default_nettype none
// ============================================================================
//  Module      : key_conditioner_if
//  Description : Button-side bundle of the key conditioner. It carries the raw
//                active-low keys into the block and the conditioned levels and
//                event pulses out to the recorder/player controller.
//                  i_key_n   [N_KEYS] raw buttons, active-low, asynchronous
//                  o_level   [N_KEYS] debounced pressed level, 1 = held
//                  o_press   [N_KEYS] one-cycle press event, one-hot or zero
//                  o_release [N_KEYS] one-cycle release event
//                  o_long    [N_KEYS] one-cycle long-press event
//                  o_pending          a press is still queued for emission
//                Modport slave is the conditioner; modport master is whatever
//                drives the keys and consumes the events.
//  Revision    : 1.0 - initial release
// ============================================================================
interface key_conditioner_if #(
    parameter int N_KEYS = 3
);
    logic [N_KEYS-1:0] i_key_n;
    logic [N_KEYS-1:0] o_level;
    logic [N_KEYS-1:0] o_press;
    logic [N_KEYS-1:0] o_release;
    logic [N_KEYS-1:0] o_long;
    logic              o_pending;

    modport slave (
        input  i_key_n,
        output o_level,
        output o_press,
        output o_release,
        output o_long,
        output o_pending
    );

    modport master (
        output i_key_n,
        input  o_level,
        input  o_press,
        input  o_release,
        input  o_long,
        input  o_pending
    );
endinterface
`default_nettype wire

// File: rtl/key_conditioner.sv
`default_nettype none
// ============================================================================
//  Module      : key_conditioner
//  Description : Converts raw active-low push buttons into debounced levels
//                and one-cycle press/release events. Each key runs through a
//                2-FF synchronizer and a 4-state debounce FSM. Press events
//                are queued in pending bits and emitted one per cycle, lowest
//                index first, so the controller never sees two presses in the
//                same cycle. Release events are not arbitrated.
//  Ports       : i_clk  - system clock
//                i_rst  - synchronous active-high reset
//                bus    - key_conditioner_if.slave (keys in, events out)
//  Options     : `define KEY_LONG_PRESS_EN adds a per-key hold counter that
//                fires one o_long pulse after LONG_CYC cycles of debounced
//                hold; without it o_long is tied low and no counter exists.
//  Revision    : 1.0 - initial release
// ============================================================================
module key_conditioner #(
    parameter int N_KEYS       = 3,
    parameter int DEBOUNCE_CYC = 500000,
    parameter int CNT_W        = 20,
    parameter int LONG_CYC     = 50000000,
    parameter int LONG_W       = 26
) (
    input wire logic          i_clk,
    input wire logic          i_rst,
    key_conditioner_if.slave  bus
);

    // Elaboration-time sanity checks on the counter sizing.
    if (DEBOUNCE_CYC < 2) begin : g_chk_deb
        $error("key_conditioner: DEBOUNCE_CYC must be at least 2");
    end
    if ((64'd1 << CNT_W) <= 64'(DEBOUNCE_CYC)) begin : g_chk_cnt_w
        $error("key_conditioner: CNT_W too narrow for DEBOUNCE_CYC");
    end
    if ((64'd1 << LONG_W) <= 64'(LONG_CYC)) begin : g_chk_long_w
        $error("key_conditioner: LONG_W too narrow for LONG_CYC");
    end

    typedef enum logic [1:0] {
        S_UP      = 2'd0,
        S_DN_WAIT = 2'd1,
        S_DOWN    = 2'd2,
        S_UP_WAIT = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] c_DEB_MAX = CNT_W'(DEBOUNCE_CYC - 1);
`ifdef KEY_LONG_PRESS_EN
    localparam logic [LONG_W-1:0] c_LONG_MAX = LONG_W'(LONG_CYC - 1);
`endif

    logic [N_KEYS-1:0] r_sync1;
    logic [N_KEYS-1:0] r_sync2;
    logic [N_KEYS-1:0] w_set;
    logic [N_KEYS-1:0] w_rel;
    logic [N_KEYS-1:0] w_level;
    logic [N_KEYS-1:0] w_long;
    logic [N_KEYS-1:0] w_pend_all;
    logic [N_KEYS-1:0] w_grant;
    logic [N_KEYS-1:0] w_pend_left;
    logic [N_KEYS-1:0] r_pend;
    logic [N_KEYS-1:0] r_press;
    logic [N_KEYS-1:0] r_release;
    logic              r_pending;

    // Two-stage synchronizer; a pressed key (low pin) becomes a 1 here.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= ~bus.i_key_n;
            r_sync2 <= r_sync1;
        end
    end

    for (genvar gi = 0; gi < N_KEYS; gi++) begin : g_key
        state_t           r_state;
        state_t           w_state_nxt;
        logic [CNT_W-1:0] r_cnt;
        logic [CNT_W-1:0] w_cnt_nxt;
        logic             w_set_k;
        logic             w_rel_k;

        always_ff @(posedge i_clk) begin
            if (i_rst) begin
                r_state <= S_UP;
                r_cnt   <= '0;
            end else begin
                r_state <= w_state_nxt;
                r_cnt   <= w_cnt_nxt;
            end
        end

        // The counter only advances while it is below the terminal value,
        // so it saturates rather than wraps.
        always_comb begin
            w_state_nxt = r_state;
            w_cnt_nxt   = r_cnt;
            w_set_k     = 1'b0;
            w_rel_k     = 1'b0;
            case (r_state)
                S_UP: begin
                    if (r_sync2[gi]) begin
                        w_state_nxt = S_DN_WAIT;
                        w_cnt_nxt   = '0;
                    end
                end
                S_DN_WAIT: begin
                    if (!r_sync2[gi]) begin
                        w_state_nxt = S_UP;
                    end else if (r_cnt == c_DEB_MAX) begin
                        w_state_nxt = S_DOWN;
                        w_set_k     = 1'b1;
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end
                S_DOWN: begin
                    if (!r_sync2[gi]) begin
                        w_state_nxt = S_UP_WAIT;
                        w_cnt_nxt   = '0;
                    end
                end
                S_UP_WAIT: begin
                    if (r_sync2[gi]) begin
                        w_state_nxt = S_DOWN;
                    end else if (r_cnt == c_DEB_MAX) begin
                        w_state_nxt = S_UP;
                        w_rel_k     = 1'b1;
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    w_state_nxt = S_UP;
                    w_cnt_nxt   = '0;
                end
            endcase
        end

        assign w_set[gi]   = w_set_k;
        assign w_rel[gi]   = w_rel_k;
        assign w_level[gi] = (r_state == S_DOWN) || (r_state == S_UP_WAIT);

`ifdef KEY_LONG_PRESS_EN
        logic [LONG_W-1:0] r_lcnt;
        logic              r_long_k;

        // Counts throughout the debounced hold, including a release bounce
        // back into S_DOWN. Saturation at the terminal value gives exactly
        // one pulse per hold; only S_UP/S_DN_WAIT rearm it.
        always_ff @(posedge i_clk) begin
            if (i_rst) begin
                r_lcnt   <= '0;
                r_long_k <= 1'b0;
            end else begin
                r_long_k <= 1'b0;
                if ((r_state == S_DOWN) || (r_state == S_UP_WAIT)) begin
                    if (r_lcnt != c_LONG_MAX) begin
                        r_lcnt   <= r_lcnt + LONG_W'(1);
                        r_long_k <= ((r_lcnt + LONG_W'(1)) == c_LONG_MAX);
                    end
                end else begin
                    r_lcnt <= '0;
                end
            end
        end

        assign w_long[gi] = r_long_k;
`else
        assign w_long[gi] = 1'b0;
`endif
    end

    // Press arbiter: a set arriving this cycle joins the queue before the
    // pick, so an uncontested press is emitted with no extra latency. OR-ing
    // a new set into an already pending bit absorbs the duplicate.
    always_comb begin
        w_pend_all  = r_pend | w_set;
        w_grant     = w_pend_all & (~w_pend_all + N_KEYS'(1));
        w_pend_left = w_pend_all & ~w_grant;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pend    <= '0;
            r_press   <= '0;
            r_release <= '0;
            r_pending <= 1'b0;
        end else begin
            r_pend    <= w_pend_left;
            r_press   <= w_grant;
            r_release <= w_rel;
            r_pending <= |w_pend_left;
        end
    end

    assign bus.o_level   = w_level;
    assign bus.o_press   = r_press;
    assign bus.o_release = r_release;
    assign bus.o_long    = w_long;
    assign bus.o_pending = r_pending;

endmodule
`default_nettype wire

// File: tb/tb_key_conditioner.sv
`default_nettype none
// ============================================================================
//  Module      : tb_key_conditioner
//  Description : Directed bench for key_conditioner with DEBOUNCE_CYC=4 and
//                LONG_CYC=20. Stimulus pushes expected output snapshots, each
//                tagged with the clock cycle it is due, into a queue; a
//                monitor on the falling edge pops and compares them, and in
//                every other cycle requires all event outputs to be quiet.
//                A key change driven just after edge c is first sampled at
//                edge c+1, so its debounced effect appears after edge c+7.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_key_conditioner;

    localparam int N_KEYS   = 3;
    localparam int DEB      = 4;
    localparam int CNT_W    = 20;
    localparam int LONG_CYC = 20;
    localparam int LONG_W   = 26;

`ifdef KEY_LONG_PRESS_EN
    localparam logic [2:0] c_LONG_K2 = 3'b100;
`else
    localparam logic [2:0] c_LONG_K2 = 3'b000;
`endif

    typedef struct {
        int         cyc;
        logic [2:0] level;
        logic [2:0] press;
        logic [2:0] rel;
        logic [2:0] lng;
        logic       pend;
        string      name;
    } exp_t;

    logic i_clk = 1'b0;
    logic i_rst;
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;
    bit   done   = 1'b0;
    exp_t q[$];
    exp_t e;

    key_conditioner_if #(.N_KEYS(N_KEYS)) u_if ();

    key_conditioner #(
        .N_KEYS       (N_KEYS),
        .DEBOUNCE_CYC (DEB),
        .CNT_W        (CNT_W),
        .LONG_CYC     (LONG_CYC),
        .LONG_W       (LONG_W)
    ) dut (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .bus   (u_if.slave)
    );

    always #5 i_clk = ~i_clk;

    always @(posedge i_clk) cyc <= cyc + 1;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge i_clk);
            #1;
        end
    endtask

    task automatic push(input int c, input logic [2:0] lv, input logic [2:0] pr,
                        input logic [2:0] rl, input logic [2:0] lg,
                        input logic pd, input string nm);
        exp_t x;
        x.cyc   = c;
        x.level = lv;
        x.press = pr;
        x.rel   = rl;
        x.lng   = lg;
        x.pend  = pd;
        x.name  = nm;
        q.push_back(x);
    endtask

    // Monitor / scoreboard
    always @(negedge i_clk) begin
        if (cyc >= 1) begin
            if (q.size() > 0 && q[0].cyc < cyc) begin
                e = q.pop_front();
                checks++;
                errors++;
                $display("FAIL %s: expectation for cycle %0d never compared (now %0d)",
                         e.name, e.cyc, cyc);
            end
            if (q.size() > 0 && q[0].cyc == cyc) begin
                e = q.pop_front();
                checks++;
                if ({u_if.o_level, u_if.o_press, u_if.o_release, u_if.o_long, u_if.o_pending}
                    !== {e.level, e.press, e.rel, e.lng, e.pend}) begin
                    errors++;
                    $display("FAIL %s @%0d: got lvl=%b prs=%b rel=%b lng=%b pend=%b, want lvl=%b prs=%b rel=%b lng=%b pend=%b",
                             e.name, cyc, u_if.o_level, u_if.o_press, u_if.o_release,
                             u_if.o_long, u_if.o_pending, e.level, e.press, e.rel,
                             e.lng, e.pend);
                end
            end else begin
                checks++;
                if ((u_if.o_press | u_if.o_release | u_if.o_long) !== 3'b000) begin
                    errors++;
                    $display("FAIL idle_pulse @%0d: got prs=%b rel=%b lng=%b, want all 000",
                             cyc, u_if.o_press, u_if.o_release, u_if.o_long);
                end
            end
        end
        if (done) begin
            checks++;
            if (q.size() != 0) begin
                errors++;
                $display("FAIL leftover: got %0d unchecked expectations, want 0", q.size());
            end
            $display("CHECKS %0d ERRORS %0d", checks, errors);
            $finish;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int c1;
        int lv;
        int c3;
        // Reset held for 3 edges while key0 is already pressed.
        i_rst        = 1'b1;
        u_if.i_key_n = 3'b110;
        for (int c = 1; c <= 3; c++) push(c, 3'b000, 3'b000, 3'b000, 3'b000, 1'b0, "reset_zero");
        step(3);                                   // cyc = 3
        i_rst = 1'b0;
        push(9,  3'b000, 3'b000, 3'b000, 3'b000, 1'b0, "key0_early");
        push(10, 3'b001, 3'b001, 3'b000, 3'b000, 1'b0, "key0_press");
        push(11, 3'b001, 3'b000, 3'b000, 3'b000, 1'b0, "key0_hold");
        step(8);                                   // cyc = 11
        u_if.i_key_n = 3'b111;
        push(17, 3'b001, 3'b000, 3'b000, 3'b000, 1'b0, "key0_rel_wait");
        push(18, 3'b000, 3'b000, 3'b001, 3'b000, 1'b0, "key0_release");
        step(7);                                   // cyc = 18

        // Bounce on key1: 2 cycles low / 2 cycles high, 20 cycles total.
        for (int k = 0; k < 5; k++) begin
            u_if.i_key_n = 3'b101;
            step(2);
            u_if.i_key_n = 3'b111;
            step(2);
        end
        c1 = cyc;
        push(c1 + 1, 3'b000, 3'b000, 3'b000, 3'b000, 1'b0, "bounce_quiet");
        u_if.i_key_n = 3'b101;                      // stable low from here
        push(c1 + 6, 3'b000, 3'b000, 3'b000, 3'b000, 1'b0, "key1_early");
        push(c1 + 7, 3'b010, 3'b010, 3'b000, 3'b000, 1'b0, "key1_press");
        lv = c1 + 7;
        step(9);                                   // cyc = lv + 2
        u_if.i_key_n = 3'b111;                      // 2-cycle release glitch
        step(2);
        u_if.i_key_n = 3'b101;
        push(lv + 10, 3'b010, 3'b000, 3'b000, 3'b000, 1'b0, "glitch_hold");
        step(6);                                   // cyc = lv + 10
        u_if.i_key_n = 3'b111;
        push(lv + 16, 3'b010, 3'b000, 3'b000, 3'b000, 1'b0, "key1_rel_wait");
        push(lv + 17, 3'b000, 3'b000, 3'b010, 3'b000, 1'b0, "key1_release");
        step(8);

        // key0 and key2 pressed on the same edge.
        c3 = cyc;
        u_if.i_key_n = 3'b010;
        push(c3 + 7, 3'b101, 3'b001, 3'b000, 3'b000, 1'b1, "simul_first");
        push(c3 + 8, 3'b101, 3'b100, 3'b000, 3'b000, 1'b0, "simul_second");
        step(9);                                   // cyc = c3 + 9
        u_if.i_key_n = 3'b011;                      // key0 let go, key2 held
        push(c3 + 16, 3'b100, 3'b000, 3'b001, 3'b000, 1'b0, "key0_release2");
        push(c3 + 26, 3'b100, 3'b000, 3'b000, c_LONG_K2, 1'b0, "key2_long");
        step(31);                                  // cyc = c3 + 40
        u_if.i_key_n = 3'b111;
        push(c3 + 46, 3'b100, 3'b000, 3'b000, 3'b000, 1'b0, "key2_rel_wait");
        push(c3 + 47, 3'b000, 3'b000, 3'b100, 3'b000, 1'b0, "key2_release");
        step(10);
        done = 1'b1;
    end

endmodule
`default_nettype wire
